// File: rtl/bus_ctrl.sv
// rtl/bus_ctrl.sv - handshaked CPU-to-IO bus controller: NDEV devices plus a data-memory window
// Optional wait-state timeout is built when BUS_TIMEOUT_EN is defined.
module bus_ctrl #(
    parameter int          NDEV     = 4,
    parameter logic [3:0]  MEM_BASE = 4'h1,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      c_req,
    input  logic                      c_we,
    input  logic [31:0]               c_address,
    input  logic [31:0]               c_wdata,
    output logic [31:0]               c_rdata,
    output logic                      c_ready,
    output logic                      c_err,
    output logic [11:0]               io_address,
    output logic [NDEV:0]             io_cs,
    output logic                      io_we,
    output logic [31:0]               io_wdata,
    input  logic [32*(NDEV+1)-1:0]    io_rdata,
    input  logic [NDEV:0]             io_ready
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [11:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [NDEV:0] sel_q, sel_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic [NDEV:0] dec_sel;
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          timeout_hit;

    // Memory window takes priority so MEM_BASE==0 shadows the device range.
    always_comb begin
        dec_sel = '0;
        if (c_address[15:12] == MEM_BASE) begin
            dec_sel[NDEV] = 1'b1;
        end else if (c_address[15:12] == 4'h0) begin
            for (int k = 0; k < NDEV; k++) begin
                if (c_address[11:8] == 4'(k)) begin
                    dec_sel[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_ready = |(io_ready & sel_q);
        sel_rdata = '0;
        for (int k = 0; k <= NDEV; k++) begin
            if (sel_q[k]) begin
                sel_rdata = sel_rdata | io_rdata[32*k +: 32];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        unused_addr;

    always_comb begin
        cnt_d = '0;
        if (state_q == S_ACCESS && !sel_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (state_q == S_ACCESS) && (cnt_q == TO_LAST);
    assign unused_addr = ^c_address[31:16];
`else
    logic [16:0] unused_cfg;

    assign timeout_hit = 1'b0;
    assign unused_cfg  = {^c_address[31:16], 16'(TIMEOUT)};
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (c_req) begin
                    if (|dec_sel) begin
                        addr_d  = c_address[11:0];
                        we_d    = c_we;
                        wdata_d = c_wdata;
                        sel_d   = dec_sel;
                        state_d = S_ACCESS;
                    end else begin
                        rdata_d = ERR_DATA;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ACCESS: begin
                // A ready in the expiry cycle still counts as a normal completion.
                if (sel_ready) begin
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    ready_d = 1'b1;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    rdata_d = ERR_DATA;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign c_rdata    = rdata_q;
    assign c_ready    = ready_q;
    assign c_err      = err_q;
    assign io_address = addr_q;
    assign io_wdata   = wdata_q;
    assign io_cs      = (state_q == S_ACCESS) ? sel_q : '0;
    assign io_we      = (state_q == S_ACCESS) && we_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// tb/tb_bus_ctrl.sv - table-driven bench for bus_ctrl, plus reset, stray-ready and timeout sequences
module tb_bus_ctrl;
    localparam int          NDEV = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we;
    logic [31:0]   c_address, c_wdata, c_rdata;
    logic          c_ready, c_err;
    logic [11:0]   io_address;
    logic [NDEV:0] io_cs;
    logic          io_we;
    logic [31:0]   io_wdata;
    logic [32*(NDEV+1)-1:0] io_rdata;
    logic [NDEV:0] io_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_ctrl #(.NDEV(NDEV), .MEM_BASE(4'h1), .TIMEOUT(8), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst(rst), .c_req(c_req), .c_we(c_we), .c_address(c_address),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready), .c_err(c_err),
        .io_address(io_address), .io_cs(io_cs), .io_we(io_we), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ready(io_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          tgt;
        int          dly;
        logic [4:0]  cs;
        int          ncs;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                input int tgt, input int dly, input logic [4:0] cs, input int ncs,
                                input int lat, input logic [31:0] rd, input logic err);
        vec_t v;
        v.addr = a; v.we = we; v.wdata = wd; v.tgt = tgt; v.dly = dly;
        v.cs = cs; v.ncs = ncs; v.lat = lat; v.rdata = rd; v.err = err;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(c_ready), 32'h0);
        chk({tag, "_err"}, 32'(c_err), 32'h0);
        chk({tag, "_rdata"}, c_rdata, 32'h0);
        chk({tag, "_cs"}, 32'(io_cs), 32'h0);
        chk({tag, "_we"}, 32'(io_we), 32'h0);
        chk({tag, "_addr"}, 32'(io_address), 32'h0);
        chk({tag, "_wdata"}, io_wdata, 32'h0);
    endtask

    // Non-target io_ready bits are held high as noise; the target bit rises after dly ACCESS cycles.
    task automatic run_vec(input vec_t v, input string tag);
        int   n_cs;
        int   lat;
        logic got;
        logic [4:0] tmask;
        tmask     = 5'b00001 << v.tgt;
        io_ready  = ~tmask;
        c_req     = 1'b1;
        c_we      = v.we;
        c_address = v.addr;
        c_wdata   = v.wdata;
        n_cs = 0;
        lat  = 0;
        got  = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            c_address = 32'h0000_0F00;
            c_we      = ~v.we;
            c_wdata   = 32'h0;
            if (io_cs != '0) begin
                n_cs++;
                chk({tag, "_cs"}, 32'(io_cs), 32'(v.cs));
                chk({tag, "_iowe"}, 32'(io_we), 32'(v.we));
                chk({tag, "_ioaddr"}, 32'(io_address), {20'h0, v.addr[11:0]});
                if (v.we) chk({tag, "_iowdata"}, io_wdata, v.wdata);
                if (n_cs > v.dly) io_ready = '1;
            end
            if (c_ready) begin
                got      = 1'b1;
                c_req    = 1'b0;
                io_ready = '0;
            end
        end
        chk({tag, "_done"}, 32'(got), 32'h1);
        chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
        chk({tag, "_ncs"}, 32'(n_cs), 32'(v.ncs));
        chk({tag, "_rdata"}, c_rdata, v.rdata);
        chk({tag, "_err"}, 32'(c_err), 32'(v.err));
        c_req    = 1'b0;
        io_ready = '0;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(c_ready), 32'h0);
        chk({tag, "_errpulse"}, 32'(c_err), 32'h0);
        chk({tag, "_idlecs"}, 32'(io_cs), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        c_req     = 1'b0;
        c_we      = 1'b0;
        c_address = '0;
        c_wdata   = '0;
        io_ready  = '0;
        io_rdata  = {32'hD4D4_0004, 32'hC3C3_0003, 32'h1234_5678, 32'hB1B1_0001, 32'hA0A0_0000};

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        //                addr          we    wdata          tgt dly cs        ncs lat rdata          err
        vecs.push_back(mk(32'h0000_0204, 1'b0, 32'h0,          2,  0, 5'b00100, 1,  2, 32'h1234_5678, 1'b0));
        vecs.push_back(mk(32'h0000_1010, 1'b1, 32'hCAFE_F00D, 4,  3, 5'b10000, 4,  5, 32'h0,         1'b0));
        vecs.push_back(mk(32'h0000_0500, 1'b0, 32'h0,          0,  0, 5'b00000, 0,  1, ERRD,          1'b1));
        vecs.push_back(mk(32'h0000_1FFC, 1'b0, 32'h0,          4,  1, 5'b10000, 2,  3, 32'hD4D4_0004, 1'b0));
        vecs.push_back(mk(32'h0000_0000, 1'b0, 32'h0,          0,  0, 5'b00001, 1,  2, 32'hA0A0_0000, 1'b0));
        vecs.push_back(mk(32'h0000_03FF, 1'b0, 32'h0,          3,  2, 5'b01000, 3,  4, 32'hC3C3_0003, 1'b0));
        vecs.push_back(mk(32'h0000_2000, 1'b1, 32'h1111_2222, 0,  0, 5'b00000, 0,  1, ERRD,          1'b1));
        vecs.push_back(mk(32'hFFFF_0104, 1'b0, 32'h0,          1,  0, 5'b00010, 1,  2, 32'hB1B1_0001, 1'b0));
        vecs.push_back(mk(32'h0000_0108, 1'b1, 32'h5555_AAAA, 1,  0, 5'b00010, 1,  2, 32'h0,         1'b0));
        vecs.push_back(mk(32'h0000_0F00, 1'b0, 32'h0,          0,  0, 5'b00000, 0,  1, ERRD,          1'b1));
`ifdef BUS_TIMEOUT_EN
        vecs.push_back(mk(32'h0000_0000, 1'b0, 32'h0,          0, 100, 5'b00001, 8, 9, ERRD,          1'b1));
        vecs.push_back(mk(32'h0000_0000, 1'b0, 32'h0,          0,  7, 5'b00001, 8,  9, 32'hA0A0_0000, 1'b0));
        vecs.push_back(mk(32'h0000_0000, 1'b0, 32'h0,          0,  6, 5'b00001, 7,  8, 32'hA0A0_0000, 1'b0));
`else
        vecs.push_back(mk(32'h0000_0000, 1'b0, 32'h0,          0, 20, 5'b00001, 21, 22, 32'hA0A0_0000, 1'b0));
`endif
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset during ACCESS aborts the transfer without a completion.
        io_ready  = '0;
        c_req     = 1'b1;
        c_we      = 1'b1;
        c_address = 32'h0000_01AB;
        c_wdata   = 32'h7777_0000;
        @(posedge clk); #1;
        chk("rstmid_cs", 32'(io_cs), 32'h2);
        chk("rstmid_addr", 32'(io_address), 32'h1AB);
        @(posedge clk); #1;
        rst   = 1'b1;
        c_req = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("rstmid");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_noready", 32'(c_ready), 32'h0);
        run_vec(mk(32'h0000_0100, 1'b0, 32'h0, 1, 1, 5'b00010, 2, 3, 32'hB1B1_0001, 1'b0), "after_rst");

        // A ready from a non-selected device must not complete the transfer.
        c_req     = 1'b1;
        c_we      = 1'b0;
        c_address = 32'h0000_0100;
        @(posedge clk); #1;
        chk("stray_cs0", 32'(io_cs), 32'h2);
        io_ready = 5'b01000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("stray_noready", 32'(c_ready), 32'h0);
            chk("stray_cs", 32'(io_cs), 32'h2);
        end
        io_ready = 5'b00010;
        @(posedge clk); #1;
        chk("stray_ready", 32'(c_ready), 32'h1);
        chk("stray_rdata", c_rdata, 32'hB1B1_0001);
        chk("stray_err", 32'(c_err), 32'h0);
        c_req    = 1'b0;
        io_ready = '0;
        @(posedge clk); #1;
        chk("stray_pulse", 32'(c_ready), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule
